// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 SR/Cause/EPC with exception and interrupt request logic; optional Count/Compare timer under CP0_TIMER_EN
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] PC_MIN    = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exccode_in,
  input  logic [5:0]  hwint,
  input  logic        exl_clr,
  output logic        req,
  output logic [31:0] exc_pc,
  output logic [31:0] epc_out
);
  logic [5:0]  im, ip, hw_eff;
  logic        exl, ie, bd;
  logic [4:0]  exccode;
  logic [31:0] epc, sr, cause, epc_n, epc_w;
  logic        int_req, exc_req, wr_sr, wr_epc;
  assign sr      = {16'b0, im, 8'b0, exl, ie};
  assign cause   = {bd, 15'b0, ip, 3'b0, exccode, 2'b0};
  assign epc_out = epc;
  assign exc_pc  = EXC_ENTRY;
  assign int_req = ie & ~exl & |(hw_eff & im);
  assign exc_req = ~exl & (exccode_in != 5'd0);
  assign req     = int_req | exc_req;
  assign wr_sr   = we & ~req & (cp0_addr == 5'd12);
  assign wr_epc  = we & ~req & (cp0_addr == 5'd14);
  assign epc_n   = bd_in ? vpc - 32'd4 : vpc;
  assign epc_w   = ({cp0_wdata[31:2], 2'b00} < PC_MIN) ? PC_MIN : {cp0_wdata[31:2], 2'b00};
`ifdef CP0_TIMER_EN
  logic [31:0] count, compare;
  logic        timer_pend, wr_cmp;
  assign wr_cmp = we & ~req & (cp0_addr == 5'd11);
  assign hw_eff = {hwint[5] | timer_pend, hwint[4:0]};
  // free-running counter; a match latches a pending timer interrupt until Compare is rewritten
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= 32'd0;
      compare    <= 32'd0;
      timer_pend <= 1'b0;
    end else begin
      count <= count + 32'd1;
      if (wr_cmp) compare <= cp0_wdata;
      timer_pend <= wr_cmp ? 1'b0 : (timer_pend | (count == compare));
    end
  end
  // register read, no bypass of same-cycle writes
  always_comb
    cp0_rdata = (cp0_addr == 5'd12) ? sr :
                (cp0_addr == 5'd13) ? cause :
                (cp0_addr == 5'd14) ? epc :
                (cp0_addr == 5'd9)  ? count :
                (cp0_addr == 5'd11) ? compare : 32'd0;
`else
  assign hw_eff = hwint;
  // register read, no bypass of same-cycle writes
  always_comb
    cp0_rdata = (cp0_addr == 5'd12) ? sr :
                (cp0_addr == 5'd13) ? cause :
                (cp0_addr == 5'd14) ? epc : 32'd0;
`endif
  // exception entry beats eret which beats mtc0; IP tracks the lines every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      im      <= 6'd0;
      ip      <= 6'd0;
      exl     <= 1'b0;
      ie      <= 1'b0;
      bd      <= 1'b0;
      exccode <= 5'd0;
      epc     <= 32'd0;
    end else begin
      ip <= hw_eff;
      if (req) begin
        exl     <= 1'b1;
        exccode <= int_req ? 5'd0 : exccode_in;
        bd      <= bd_in;
        epc     <= {epc_n[31:2], 2'b00};
      end else begin
        if (wr_sr) begin
          im  <= cp0_wdata[15:10];
          ie  <= cp0_wdata[0];
          exl <= cp0_wdata[1];
        end
        if (wr_epc) epc <= epc_w;
        if (exl_clr) exl <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed self-checking bench for cp0_exc_ctrl
module tb_cp0_exc_ctrl;
  logic        clk = 1'b0, reset = 1'b1, we = 1'b0, bd_in = 1'b0, exl_clr = 1'b0, req;
  logic [4:0]  cp0_addr = 5'd0, exccode_in = 5'd0;
  logic [31:0] cp0_wdata = 32'd0, cp0_rdata, vpc = 32'd0, exc_pc, epc_out;
  logic [5:0]  hwint = 6'd0;
  int asserts = 0, failures = 0;
  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset), .we(we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .cp0_rdata(cp0_rdata), .vpc(vpc), .bd_in(bd_in), .exccode_in(exccode_in),
    .hwint(hwint), .exl_clr(exl_clr), .req(req), .exc_pc(exc_pc), .epc_out(epc_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    asserts++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    check(tag, cp0_rdata, exp);
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1;
    cp0_addr = a;
    cp0_wdata = d;
    tick();
    we = 1'b0;
  endtask
  task automatic eret;
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    rd("rst_sr", 5'd12, 32'd0);
    rd("rst_cause", 5'd13, 32'd0);
    rd("rst_epc", 5'd14, 32'd0);
    check("rst_epc_out", epc_out, 32'd0);
    check("exc_pc", exc_pc, 32'h0000_4180);
    hwint = 6'h3f;
    #1;
    check("rst_req", {31'd0, req}, 32'd0);
    hwint = 6'd0;
    wr(5'd12, 32'h0000_0401);
    rd("sr_write", 5'd12, 32'h0000_0401);
    hwint = 6'b000001;
    vpc = 32'h0000_3010;
    #1;
    check("int_req", {31'd0, req}, 32'd1);
    tick();
    check("int_epc", epc_out, 32'h0000_3010);
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_sr", 5'd12, 32'h0000_0403);
    check("exl_masks_int", {31'd0, req}, 32'd0);
    hwint = 6'd0;
    tick();
    eret();
    rd("eret_sr", 5'd12, 32'h0000_0401);
    exccode_in = 5'd12;
    bd_in = 1'b1;
    vpc = 32'h0000_3024;
    #1;
    check("exc_req", {31'd0, req}, 32'd1);
    tick();
    exccode_in = 5'd0;
    bd_in = 1'b0;
    check("bd_epc", epc_out, 32'h0000_3020);
    rd("bd_cause", 5'd13, 32'h8000_0030);
    exccode_in = 5'd4;
    #1;
    check("exl_masks_exc", {31'd0, req}, 32'd0);
    tick();
    exccode_in = 5'd0;
    rd("masked_cause", 5'd13, 32'h8000_0030);
    eret();
    rd("eret2_sr", 5'd12, 32'h0000_0401);
    check("eret_epc", epc_out, 32'h0000_3020);
    exccode_in = 5'd10;
    vpc = 32'h0000_3040;
    we = 1'b1;
    cp0_addr = 5'd14;
    cp0_wdata = 32'h0000_5000;
    #1;
    check("exc_vs_mtc0_req", {31'd0, req}, 32'd1);
    tick();
    we = 1'b0;
    exccode_in = 5'd0;
    check("mtc0_lost", epc_out, 32'h0000_3040);
    rd("exc10_cause", 5'd13, 32'h0000_0028);
    eret();
    hwint = 6'b000001;
    exccode_in = 5'd8;
    tick();
    rd("int_wins_cause", 5'd13, 32'h0000_0400);
    hwint = 6'd0;
    exccode_in = 5'd0;
    eret();
    wr(5'd14, 32'h0000_1003);
    check("epc_clamp", epc_out, 32'h0000_3000);
    wr(5'd14, 32'h0000_6007);
    check("epc_align", epc_out, 32'h0000_6004);
    exccode_in = 5'd4;
    tick();
    exccode_in = 5'd0;
    exl_clr = 1'b1;
    wr(5'd12, 32'h0000_fc03);
    exl_clr = 1'b0;
    rd("eret_mtc0_sr", 5'd12, 32'h0000_fc01);
    wr(5'd13, 32'hffff_ffff);
    rd("cause_ro", 5'd13, 32'h0000_0010);
    wr(5'd5, 32'hffff_ffff);
    rd("unmapped", 5'd5, 32'd0);
    hwint = 6'b100000;
    #1;
    check("im5_req", {31'd0, req}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hwint = 6'd0;
    rd("rst_wins_sr", 5'd12, 32'd0);
    check("rst_wins_epc", epc_out, 32'd0);
`ifdef CP0_TIMER_EN
    wr(5'd11, 32'd20);
    wr(5'd12, 32'h0000_8001);
    begin
      int n;
      n = 0;
      cp0_addr = 5'd9;
      #1;
      while (!req && n < 100) begin
        tick();
        #1;
        n++;
      end
      check("timer_req", {31'd0, req}, 32'd1);
      check("timer_count", cp0_rdata, 32'd21);
    end
    tick();
    rd("timer_ip", 5'd13, 32'h0000_8000);
    wr(5'd11, 32'd1000);
    tick();
    rd("timer_ip_clr", 5'd13, 32'd0);
`else
    wr(5'd11, 32'd20);
    rd("no_compare", 5'd11, 32'd0);
    rd("no_count", 5'd9, 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
